fwd_bypass_network: RTL and testbench
=====================================

# fwd_bypass_network

Parametrised operand-forwarding and load-use hazard block for the pipelined MIPS datapath. Sits at the ID/EX boundary. It tracks the destination registers of up to DEPTH in-flight instructions in an internal shift register. For each of NUM_SRC source operands, it selects either register-file data or the result of the youngest in-flight producer. When the youngest producer is a load whose data is not yet available, it raises a stall and injects a bubble. It generalises the fixed three-way 64-bit operand mux to any width, any depth and any operand count, with its own hazard tracking.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- REG_AW, 5, register index width
- NUM_SRC, 2, operand channels per instruction
- DEPTH, 3, tracked stages (index 0 = EX, 1 = MEM, 2 = WB)
- LOAD_STAGE, 1, first stage index at which load data is valid on stage_data
- SEL_W, $clog2(DEPTH+1), width of each select field
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_advance  in  1  pipeline moves this cycle; 0 = global freeze, tracker holds
- flush  in  1  ID instruction is killed; inserted entry is a bubble
- id_valid  in  1  valid instruction in ID
- id_reg_write  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load
- id_dst_reg  in  REG_AW  destination of the ID instruction
- id_src_reg  in  NUM_SRC*REG_AW  source indices; channel i at bits [i*REG_AW +: REG_AW]
- id_rf_data  in  NUM_SRC*DATA_W  register-file read data per channel
- stage_data  in  DEPTH*DATA_W  result bus of stage k at [k*DATA_W +: DATA_W]
- op_data  out  NUM_SRC*DATA_W  selected operand per channel
- op_sel  out  NUM_SRC*SEL_W  per channel: 0 = register file, k+1 = stage k
- stall  out  1  load-use hazard; ID must hold
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1

## Operation
- Tracker: DEPTH entries of {v, ld, dst}.
- Match, channel i vs entry k: v[k] & (dst[k] == src_i) & (src_i != 0). Register 0 is never forwarded.
- Priority: the lowest matching k (youngest producer) wins. Older matches are ignored.
- Channel i, winner k:
  - If ld[k]=1 and k < LOAD_STAGE: hazard_i=1, op_sel=0, op_data=rf data.
  - Otherwise: op_sel=k+1, op_data=stage_data[k].
- Channel i, no match: op_sel=0, op_data=rf data.
- stall = id_valid & OR(hazard_i). Selection is evaluated regardless of id_valid; stall is gated by it.
- Tracker update on the rising clk edge, only when pipe_advance=1:
  - entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry[DEPTH-1] is discarded.
  - entry[0] <= {1, id_is_load, id_dst_reg} if id_valid & id_reg_write & (id_dst_reg != 0) & ~stall & ~flush. Otherwise entry[0] <= bubble (v=0).
- pipe_advance=0: all entries hold. Outputs keep being recomputed from held state and current inputs.
- stall_cnt increments on each clk edge where stall=1, independent of pipe_advance. It saturates at all-ones and never wraps.
- Simultaneous events:
  - flush & stall: bubble inserted; stall still reported that cycle.
  - Same register matched in multiple entries: the youngest wins, including a non-load younger entry over an older load.
  - Both channels naming the same register resolve identically.

## Timing
- op_data, op_sel and stall are combinational from inputs and tracker state, with zero latency.
- The tracker has one cycle of latency: an instruction accepted in ID at edge n is entry[0] during cycle n+1.
- A load in EX (k=0) with LOAD_STAGE=1 stalls a dependent in ID for exactly one cycle. After the next advance it is at k=1 and forwards from stage_data[1].
- Reset (asynchronous assert, synchronous-safe deassert inside the pipeline):
  - All v=0 and stall_cnt=0.
  - Outputs during and after reset: op_sel=0, op_data=id_rf_data, stall=0.
- Reset mid-operation discards all entries immediately. No hazard persists after reset.

## Test plan
- Reset: assert rst_n=0 with arbitrary inputs. Required: stall=0, stall_cnt=0, op_sel=0 on all channels, op_data=id_rf_data.
- EX forward: issue ALU write r5; next cycle src0=r5, stage_data[0]=0x1111_2222_3333_4444. Required: op_sel0=1, op_data0=0x1111_2222_3333_4444, stall=0.
- Priority: r7 written by two back-to-back instructions, the older at k=1 and the younger at k=0; src1=r7. Required: op_sel1=1, op_data1=stage_data[0]. After two further advances with bubbles, op_sel1=3.
- Load-use: load r3 issued; next cycle src0=r3, id_valid=1. Required: stall=1 for one cycle, stall_cnt=1, and a bubble in entry[0]. Next cycle: op_sel0=2, op_data0=stage_data[1], stall=0.
- r0 and flush: write r0 then read r0 → op_sel=0. Issue write r9 with flush=1, then read r9 → op_sel=0 (bubble, no forward).
- Freeze and saturation: hold pipe_advance=0 with a load-use hazard for 2^CNT_W+5 cycles. Required: tracker unchanged, stall=1 throughout, stall_cnt=0xFFFF (saturated).

Source files
------------

// File: rtl/fwd_bypass_network.sv
// fwd_bypass_network
//   Operand forwarding and load-use hazard detection at the ID/EX boundary.
//   A DEPTH-entry shift register follows the destination registers of the
//   in-flight instructions (entry 0 = EX, 1 = MEM, 2 = WB). For each of the
//   NUM_SRC operand channels, the youngest matching producer supplies the
//   operand from stage_data. If the youngest producer is a load whose data
//   is not yet on stage_data, the block raises stall and inserts a bubble.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   pipe_advance  pipeline moves this cycle (0 = freeze, tracker holds)
//   flush         ID instruction is killed; a bubble is inserted instead
//   id_valid      ID holds a valid instruction
//   id_reg_write  ID instruction writes a register
//   id_is_load    ID instruction is a load
//   id_dst_reg    destination register of the ID instruction
//   id_src_reg    source register per channel, channel i at [i*REG_AW +: REG_AW]
//   id_rf_data    register-file read data per channel
//   stage_data    result bus of stage k at [k*DATA_W +: DATA_W]
//   op_data       selected operand per channel
//   op_sel        per channel: 0 = register file, k+1 = stage k
//   stall         load-use hazard; ID must hold
//   stall_cnt     saturating count of cycles with stall asserted
module fwd_bypass_network #(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_advance,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_reg_write,
  input  logic                        id_is_load,
  input  logic [REG_AW-1:0]           id_dst_reg,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_reg,
  input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
  input  logic [DEPTH*DATA_W-1:0]     stage_data,
  output logic [NUM_SRC*DATA_W-1:0]   op_data,
  output logic [NUM_SRC*SEL_W-1:0]    op_sel,
  output logic                        stall,
  output logic [CNT_W-1:0]            stall_cnt
);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Tracker state. Only the valid bits are reset; ld/dst are qualified by v.
  logic [DEPTH-1:0]  ent_v;
  logic [DEPTH-1:0]  ent_ld;
  logic [REG_AW-1:0] ent_dst [DEPTH];

  logic [NUM_SRC-1:0] hazard;
  logic               accept;

  // Selection. Entries are scanned oldest to youngest, so the youngest
  // match is written last and overrides everything an older match set,
  // including a hazard flagged by an older load.
  always_comb begin
    op_data = id_rf_data;
    op_sel  = '0;
    hazard  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_v[k] && (ent_dst[k] == id_src_reg[i*REG_AW +: REG_AW]) &&
            (id_src_reg[i*REG_AW +: REG_AW] != '0)) begin
          if (ent_ld[k] && (k < LOAD_STAGE)) begin
            hazard[i]                  = 1'b1;
            op_sel[i*SEL_W +: SEL_W]   = '0;
            op_data[i*DATA_W +: DATA_W] = id_rf_data[i*DATA_W +: DATA_W];
          end else begin
            hazard[i]                  = 1'b0;
            op_sel[i*SEL_W +: SEL_W]   = SEL_W'(k + 1);
            op_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign stall  = id_valid & (|hazard);
  // Writes to r0 never enter the tracker; stalled or flushed instructions
  // leave a bubble behind.
  assign accept = id_valid & id_reg_write & (id_dst_reg != '0) & ~stall & ~flush;

  // Stage boundary: ID -> tracker entry 0, entry k -> entry k+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v <= '0;
    end else if (pipe_advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        ent_v[k] <= ent_v[k-1];
      end
      ent_v[0] <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        ent_ld[k]  <= ent_ld[k-1];
        ent_dst[k] <= ent_dst[k-1];
      end
      ent_ld[0]  <= id_is_load;
      ent_dst[0] <= id_dst_reg;
    end
  end

  // Stall counter runs even while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_fwd_bypass_network.sv
// Directed testbench for fwd_bypass_network with the default parameters
// (64-bit data, 2 channels, 3 tracked stages, loads valid from stage 1).
module tb_fwd_bypass_network;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH = 3;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  logic                      clk;
  logic                      rst_n;
  logic                      pipe_advance;
  logic                      flush;
  logic                      id_valid;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic [REG_AW-1:0]         id_dst_reg;
  logic [NUM_SRC*REG_AW-1:0] id_src_reg;
  logic [NUM_SRC*DATA_W-1:0] id_rf_data;
  logic [DEPTH*DATA_W-1:0]   stage_data;
  logic [NUM_SRC*DATA_W-1:0] op_data;
  logic [NUM_SRC*SEL_W-1:0]  op_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  int n_chk;
  int n_pass;
  int bad;

  localparam logic [63:0] RF0 = 64'hAAAA_0000_0000_AAAA;
  localparam logic [63:0] RF1 = 64'hBBBB_0000_0000_BBBB;
  localparam logic [63:0] SD0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] SD1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] SD2 = 64'h9999_AAAA_BBBB_CCCC;

  fwd_bypass_network dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_advance (pipe_advance),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_dst_reg   (id_dst_reg),
    .id_src_reg   (id_src_reg),
    .id_rf_data   (id_rf_data),
    .stage_data   (stage_data),
    .op_data      (op_data),
    .op_sel       (op_sel),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Step past the next rising edge; inputs change and outputs are sampled
  // 1ns afterwards, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rw, input logic ld,
                        input logic [4:0] dst, input logic [4:0] s0, input logic [4:0] s1);
    id_valid     = v;
    id_reg_write = rw;
    id_is_load   = ld;
    id_dst_reg   = dst;
    id_src_reg   = {s1, s0};
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    bad = 0;
    rst_n = 1'b0;
    pipe_advance = 1'b1;
    flush = 1'b0;
    id_rf_data = {RF1, RF0};
    stage_data = {SD2, SD1, SD0};
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd3);

    // Reset with arbitrary inputs
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_sel", op_sel, 0);
    chk("rst_data", op_data[127:0], {RF1, RF0});
    rst_n = 1'b1;

    // EX forward
    set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("ex_sel0", op_sel[1:0], 1);
    chk("ex_data0", op_data[63:0], SD0);
    chk("ex_stall", stall, 0);
    chk("ex_sel1_r0", op_sel[3:2], 0);

    // Priority: two back-to-back writers of r7
    set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
    tick();
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7);
    #1;
    chk("pri_sel1", op_sel[3:2], 1);
    chk("pri_data1", op_data[127:64], SD0);
    chk("pri_sel0_r5_wb", op_sel[1:0], 3);
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7);
    tick();
    tick();
    chk("pri_old_sel1", op_sel[3:2], 3);
    chk("pri_old_data1", op_data[127:64], SD2);
    chk("pri_r5_gone", op_sel[1:0], 0);

    // Load-use
    set_id(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_sel0", op_sel[1:0], 0);
    chk("lu_data0", op_data[63:0], RF0);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_stall_gone", stall, 0);
    chk("lu_sel0_mem", op_sel[1:0], 2);
    chk("lu_data0_mem", op_data[63:0], SD1);
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    chk("lu_same_reg", op_sel, {2'd2, 2'd2});

    // Register 0 and flush
    set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_sel", op_sel, 0);
    set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9);
    #1;
    chk("flush_sel", op_sel, 0);
    chk("flush_data", op_data[127:0], {RF1, RF0});

    // Freeze with a load-use hazard until the counter saturates
    set_id(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0);
    pipe_advance = 1'b0;
    for (int c = 0; c < (1 << CNT_W) + 5; c++) begin
      tick();
      if (stall !== 1'b1 || op_sel[1:0] !== 2'd0) bad++;
    end
    chk("frz_stall_all", bad, 0);
    chk("frz_stall", stall, 1);
    chk("frz_cnt_sat", stall_cnt, 16'hFFFF);
    pipe_advance = 1'b1;
    tick();
    chk("frz_held_sel0", op_sel[1:0], 2);
    chk("frz_cnt_hold", stall_cnt, 16'hFFFF);

    // Asynchronous reset mid-operation
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", op_sel, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_data", op_data[127:0], {RF1, RF0});
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", op_sel, 0);
    chk("post_rst_stall", stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
